// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM states and timing constants.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;
  // Cycles spent per operand bit: DRIVE, WAIT, CAPTURE.
  localparam int BIT_CYCLES    = 3;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    WAIT,
    CAPTURE,
    DONE
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bus and the 1-bit full-adder link of the serial adder controller.
interface serial_add_ctrl_if #(
  parameter int WIDTH = serial_add_pkg::DEFAULT_WIDTH
);

  // Handshake: a request transfers on a rising CLK edge where start && ready;
  // op_a, op_b and cin_init are sampled on that same edge. done is a one-cycle
  // pulse during which sum/cout are valid; they then hold until the next done.
  logic             start;
  logic             ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin_init;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             done;

  logic             fa_a;
  logic             fa_b;
  logic             fa_cin;
  logic             fa_s;
  logic             fa_cout;

  modport slave (
    input  start, op_a, op_b, cin_init, fa_s, fa_cout,
    output ready, sum, cout, done, fa_a, fa_b, fa_cin
  );

  modport master (
    output start, op_a, op_b, cin_init, fa_s, fa_cout,
    input  ready, sum, cout, done, fa_a, fa_b, fa_cin
  );

endinterface

// File: rtl/serial_add_shifter.sv
// Operand shift registers (LSB presented to the adder) and the result shift register.
module serial_add_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             res_bit_i,
  output logic             a_lsb_o,
  output logic             b_lsb_o,
  output logic [WIDTH-1:0] res_o
);

  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  // Only WIDTH-1 earlier bits are stored; res_o appends the bit being captured now.
  logic [WIDTH-2:0] res_sh_q, res_sh_d;

  assign res_o = {res_bit_i, res_sh_q};

  always_comb begin
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    if (load_i) begin
      a_sh_d   = op_a_i;
      b_sh_d   = op_b_i;
      res_sh_d = '0;
    end else if (shift_i) begin
      a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
      b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
      res_sh_d = res_o[WIDTH-1:1];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
    end else begin
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
    end
  end

  assign a_lsb_o = a_sh_q[0];
  assign b_lsb_o = b_sh_q[0];

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add controller: feeds one operand bit per 3 cycles to an external
// registered full adder (2-cycle latency) and assembles the result word.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  serial_add_ctrl_if.slave bus,
  output state_t           state_dbg_o
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             done_q;

  logic             load;
  logic             shift;
  logic             last_bit;
  logic             a_lsb;
  logic             b_lsb;
  logic [WIDTH-1:0] res_word;

  serial_add_shifter #(.WIDTH(WIDTH)) u_shifter (
    .CLK       (CLK),
    .RST       (RST),
    .load_i    (load),
    .shift_i   (shift),
    .op_a_i    (bus.op_a),
    .op_b_i    (bus.op_b),
    .res_bit_i (bus.fa_s),
    .a_lsb_o   (a_lsb),
    .b_lsb_o   (b_lsb),
    .res_o     (res_word)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = DRIVE;
        end
      end
      DRIVE:   state_d = WAIT;
      WAIT:    state_d = CAPTURE;
      CAPTURE: begin
        shift   = 1'b1;
        state_d = last_bit ? DONE : DRIVE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= shift && last_bit;
      if (load) begin
        carry_q <= bus.cin_init;
        cnt_q   <= '0;
      end else if (shift) begin
        carry_q <= bus.fa_cout;
        // Counter parks at WIDTH-1 on the final bit instead of wrapping.
        if (!last_bit) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end else begin
          sum_q  <= res_word;
          cout_q <= bus.fa_cout;
        end
      end
    end
  end

  // Shift-register LSBs and the carry register are already flops, so the
  // adder drives are registered and stay put from DRIVE through CAPTURE.
  assign bus.fa_a    = a_lsb;
  assign bus.fa_b    = b_lsb;
  assign bus.fa_cin  = carry_q;
  assign bus.ready   = (state_q == IDLE);
  assign bus.sum     = sum_q;
  assign bus.cout    = cout_q;
  assign bus.done    = done_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl driving a registered 2-stage full adder, WIDTH=8.
module tb_serial_add_ctrl;
  import serial_add_pkg::*;

  localparam int W   = 8;
  localparam int LAT = BIT_CYCLES * W + 1;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  serial_add_ctrl_if #(.WIDTH(W)) bus();
  state_t state_dbg;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .bus         (bus.slave),
    .state_dbg_o (state_dbg)
  );

  // Downstream registered full adder: input stage, then output stage.
  logic [2:0] fa_stage_q;
  always_ff @(posedge CLK) begin
    if (RST) begin
      fa_stage_q  <= '0;
      bus.fa_s    <= 1'b0;
      bus.fa_cout <= 1'b0;
    end else begin
      fa_stage_q <= {bus.fa_a, bus.fa_b, bus.fa_cin};
      {bus.fa_cout, bus.fa_s} <= {1'b0, fa_stage_q[2]} + {1'b0, fa_stage_q[1]} + {1'b0, fa_stage_q[0]};
    end
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [W:0] exp_q[$];

  // ---------------- driver tasks ----------------
  task automatic drive_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    bus.start    = 1'b1;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.cin_init = cin;
    exp_q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin});
  endtask

  task automatic wait_done(input bit hold, output int lat, output bit seen);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 100) begin
      @(posedge CLK);
      lat++;
      @(negedge CLK);
      if (!hold) bus.start = 1'b0;
      if (bus.done === 1'b1) seen = 1'b1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if ({bus.ready, bus.done, bus.cout, bus.sum, bus.fa_a, bus.fa_b, bus.fa_cin} !== {1'b1, 1'b0, 1'b0, {W{1'b0}}, 3'b000}) begin
      failures++;
      $display("FAIL reset_outputs: ready=%b done=%b cout=%b sum=%h fa=%b%b%b, required ready=1 rest 0",
               bus.ready, bus.done, bus.cout, bus.sum, bus.fa_a, bus.fa_b, bus.fa_cin);
    end
    checks++;
    if (state_dbg !== IDLE) begin
      failures++;
      $display("FAIL reset_state: got %s required IDLE", state_dbg.name());
    end
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle: ready=%b done=%b required 1/0", bus.ready, bus.done);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] a_t[3];
    logic [W-1:0] b_t[3];
    logic         c_t[3];
    a_t = '{8'h5A, 8'hFF, 8'hFF};
    b_t = '{8'h3C, 8'h01, 8'hFF};
    c_t = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      int         lat;
      bit         seen;
      logic [W:0] e;
      drive_req(a_t[i], b_t[i], c_t[i]);
      wait_done(1'b0, lat, seen);
      checks++;
      if (!seen || lat != LAT) begin
        failures++;
        $display("FAIL directed%0d_latency: seen=%0d lat=%0d required %0d", i, seen, lat, LAT);
      end
      e = exp_q.pop_front();
      checks++;
      if ({bus.cout, bus.sum} !== e) begin
        failures++;
        $display("FAIL directed%0d_result: cout/sum=%b/%h required %b/%h", i, bus.cout, bus.sum, e[W], e[W-1:0]);
      end
      checks++;
      if (bus.ready !== 1'b0) begin
        failures++;
        $display("FAIL directed%0d_ready_in_done: got %b required 0", i, bus.ready);
      end
      @(negedge CLK);
      checks++;
      if (bus.done !== 1'b0 || bus.ready !== 1'b1) begin
        failures++;
        $display("FAIL directed%0d_pulse: done=%b ready=%b required 0/1", i, bus.done, bus.ready);
      end
      repeat (3) @(negedge CLK);
      checks++;
      if ({bus.cout, bus.sum} !== e) begin
        failures++;
        $display("FAIL directed%0d_hold: cout/sum=%b/%h required %b/%h", i, bus.cout, bus.sum, e[W], e[W-1:0]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      int         lat;
      bit         seen;
      logic [W:0] e;
      drive_req(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      wait_done(1'b0, lat, seen);
      e = exp_q.pop_front();
      checks++;
      if (!seen || lat != LAT || {bus.cout, bus.sum} !== e) begin
        failures++;
        $display("FAIL random%0d: seen=%0d lat=%0d cout/sum=%b/%h required lat %0d %b/%h",
                 i, seen, lat, bus.cout, bus.sum, LAT, e[W], e[W-1:0]);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_ignore_start();
    int         k;
    bit         seen;
    int         busy_bad;
    logic [W:0] e;
    k        = 0;
    seen     = 1'b0;
    busy_bad = 0;
    drive_req(8'h21, 8'h43, 1'b0);
    while (!seen && k < 100) begin
      @(posedge CLK);
      k++;
      @(negedge CLK);
      if (k == 5 || k == 24) begin
        bus.start    = 1'b1;
        bus.op_a     = W'($urandom_range(0, 255));
        bus.op_b     = W'($urandom_range(0, 255));
        bus.cin_init = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done === 1'b1) seen = 1'b1;
      else if (bus.ready !== 1'b0) busy_bad++;
    end
    checks++;
    if (busy_bad != 0) begin
      failures++;
      $display("FAIL ignore_ready_busy: ready high in %0d busy cycles, required 0", busy_bad);
    end
    e = exp_q.pop_front();
    checks++;
    if (!seen || k != LAT || {bus.cout, bus.sum} !== e) begin
      failures++;
      $display("FAIL ignore_result: seen=%0d lat=%0d cout/sum=%b/%h required lat %0d %b/%h",
               seen, k, bus.cout, bus.sum, LAT, e[W], e[W-1:0]);
    end
    repeat (4) @(negedge CLK);
    checks++;
    if (state_dbg !== IDLE || bus.ready !== 1'b1 || {bus.cout, bus.sum} !== e) begin
      failures++;
      $display("FAIL ignore_no_restart: state=%s ready=%b sum=%h required IDLE/1/%h",
               state_dbg.name(), bus.ready, bus.sum, e[W-1:0]);
    end
  endtask

  task automatic test_reset_mid_op();
    int         lat;
    bit         seen;
    int         stray_done;
    logic [W:0] e;
    drive_req(8'h12, 8'h34, 1'b0);
    @(posedge CLK);
    @(negedge CLK);
    bus.start = 1'b0;
    repeat (9) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    exp_q.delete();
    checks++;
    if ({bus.done, bus.cout, bus.sum, bus.fa_a, bus.fa_b, bus.fa_cin} !== '0 || bus.ready !== 1'b1) begin
      failures++;
      $display("FAIL midreset_outputs: done=%b cout=%b sum=%h fa=%b%b%b ready=%b required all 0, ready 1",
               bus.done, bus.cout, bus.sum, bus.fa_a, bus.fa_b, bus.fa_cin, bus.ready);
    end
    RST = 1'b0;
    stray_done = 0;
    repeat (30) begin
      @(negedge CLK);
      if (bus.done !== 1'b0) stray_done++;
    end
    checks++;
    if (stray_done != 0) begin
      failures++;
      $display("FAIL midreset_no_done: saw %0d done cycles, required 0", stray_done);
    end
    drive_req(8'h12, 8'h34, 1'b0);
    wait_done(1'b0, lat, seen);
    e = exp_q.pop_front();
    checks++;
    if (!seen || {bus.cout, bus.sum} !== e) begin
      failures++;
      $display("FAIL midreset_rerun: seen=%0d cout/sum=%b/%h required %b/%h", seen, bus.cout, bus.sum, e[W], e[W-1:0]);
    end
    @(negedge CLK);
  endtask

  task automatic test_back_to_back();
    int         lat;
    bit         seen;
    logic [W:0] e;
    drive_req(8'hC3, 8'h7E, 1'b1);
    wait_done(1'b1, lat, seen);
    e = exp_q.pop_front();
    checks++;
    if (!seen || lat != LAT || {bus.cout, bus.sum} !== e) begin
      failures++;
      $display("FAIL b2b_first: seen=%0d lat=%0d cout/sum=%b/%h required lat %0d %b/%h",
               seen, lat, bus.cout, bus.sum, LAT, e[W], e[W-1:0]);
    end
    // start stays high through the DONE cycle; new operands appear now.
    drive_req(8'h0F, 8'hA1, 1'b0);
    wait_done(1'b1, lat, seen);
    bus.start = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (!seen || lat != LAT + 1 || {bus.cout, bus.sum} !== e) begin
      failures++;
      $display("FAIL b2b_second: seen=%0d lat=%0d cout/sum=%b/%h required lat %0d %b/%h",
               seen, lat, bus.cout, bus.sum, LAT + 1, e[W], e[W-1:0]);
    end
    repeat (3) @(negedge CLK);
    checks++;
    if (state_dbg !== IDLE || exp_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_idle: state=%s pending=%0d required IDLE/0", state_dbg.name(), exp_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.start    = 1'b0;
    bus.op_a     = '0;
    bus.op_b     = '0;
    bus.cin_init = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_mid_op();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
